// File: rtl/kyber_pkg.sv
// kyber_pkg: Kyber modulus and word-size constants shared by the multiplier pipe.
package kyber_pkg;
  localparam int KYBER_Q  = 3329;
  localparam int KYBER_K  = 13;
  localparam int KYBER_K2 = 169;
  localparam int COEFW    = 12;
  localparam int PRODW    = 24;
  typedef struct packed {
    logic [COEFW-1:0] a;
    logic [COEFW-1:0] b;
  } opnd_t;
endpackage

// File: rtl/k2red.sv
// k2red: combinational double K-reduction for q = 13*2^8 + 1; cred is congruent to 169*c mod q.
// Ports: c (24-bit product in), cred (12-bit result in [0, 3571], not canonical).
module k2red
  import kyber_pkg::*;
(
  input  logic [PRODW-1:0] c,
  output logic [COEFW-1:0] cred
);
  logic [17:0] w_t;
  logic [12:0] w_u;
  // first pass: 13*c_lo - c_hi, range [-65535, 3315], kept as 18-bit two's complement
  assign w_t  = 18'(KYBER_K) * {10'd0, c[7:0]} - {2'd0, c[23:8]};
  // second pass with an arithmetic high part, range [-12, 3571]
  assign w_u  = 13'(KYBER_K) * {5'd0, w_t[7:0]} - {{3{w_t[17]}}, w_t[17:8]};
  // fold the small negative tail back into range so 12 bits suffice
  assign cred = w_u[12] ? 12'(w_u + 13'(KYBER_Q)) : w_u[11:0];
endmodule

// File: rtl/k2red_mulpipe.sv
// k2red_mulpipe: 3-stage valid/ready modular multiplier returning k2red(a*b) with a pass-through tag.
// Ports: in_valid/in_ready/in_a/in_b/in_tag operand side; out_valid/out_ready/out_res/out_tag
// result side; err_range sticky flag for accepted operands >= Q; busy when any stage holds data.
module k2red_mulpipe
  import kyber_pkg::*;
#(
  parameter int TAGW = 8,
  parameter int Q    = KYBER_Q
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [COEFW-1:0] in_a,
  input  logic [COEFW-1:0] in_b,
  input  logic [TAGW-1:0]  in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [COEFW-1:0] out_res,
  output logic [TAGW-1:0]  out_tag,
  output logic             err_range,
  output logic             busy
);
  localparam logic [COEFW-1:0] LQ = COEFW'(Q);
  opnd_t            r_s1;
  logic             r_v1, r_v2, r_v3, r_err;
  logic [TAGW-1:0]  r_tag1, r_tag2, r_tag3;
  logic [PRODW-1:0] r_p2;
  logic [COEFW-1:0] r_res3;
  logic             w_adv1, w_adv2, w_adv3;
  logic [PRODW-1:0] w_p;
  logic [COEFW-1:0] w_cred;
  // each stage moves when it is empty or the stage ahead moves, so bubbles collapse
  assign w_adv3    = ~r_v3 | out_ready;
  assign w_adv2    = ~r_v2 | w_adv3;
  assign w_adv1    = ~r_v1 | w_adv2;
  assign in_ready  = w_adv1;
  assign w_p       = {{(PRODW-COEFW){1'b0}}, r_s1.a} * {{(PRODW-COEFW){1'b0}}, r_s1.b};
  assign out_valid = r_v3;
  assign out_res   = r_res3;
  assign out_tag   = r_tag3;
  assign err_range = r_err;
  assign busy      = r_v1 | r_v2 | r_v3;
  k2red u_k2red (
    .c    (r_p2),
    .cred (w_cred)
  );
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_v1   <= 1'b0;
      r_v2   <= 1'b0;
      r_v3   <= 1'b0;
      r_err  <= 1'b0;
      r_s1   <= '0;
      r_tag1 <= '0;
      r_tag2 <= '0;
      r_tag3 <= '0;
      r_p2   <= '0;
      r_res3 <= '0;
    end else begin
      if (w_adv1) begin
        r_v1 <= in_valid;
        if (in_valid) begin
          r_s1   <= '{a: in_a, b: in_b};
          r_tag1 <= in_tag;
        end
      end
      if (w_adv2) begin
        r_v2 <= r_v1;
        if (r_v1) begin
          r_p2   <= w_p;
          r_tag2 <= r_tag1;
        end
      end
      if (w_adv3) begin
        r_v3 <= r_v2;
        if (r_v2) begin
          r_res3 <= w_cred;
          r_tag3 <= r_tag2;
        end
      end
      if (in_valid && w_adv1 && (in_a >= LQ || in_b >= LQ)) r_err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_k2red_mulpipe.sv
// tb_k2red_mulpipe: scoreboard bench for the k2red multiplier pipe.
module tb_k2red_mulpipe;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [11:0] in_a = '0;
  logic [11:0] in_b = '0;
  logic [7:0]  in_tag = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [11:0] out_res;
  logic [7:0]  out_tag;
  logic        err_range;
  logic        busy;

  k2red_mulpipe #(.TAGW(8), .Q(3329)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_tag(in_tag), .out_valid(out_valid),
    .out_ready(out_ready), .out_res(out_res), .out_tag(out_tag),
    .err_range(err_range), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {int a; int b; int tag; int exp;} item_t;
  item_t q[$];
  item_t e_m;
  int checks = 0, errors = 0, sent = 0, got = 0, cyc = 0;
  int first_c = -1, last_c = 0, rdy_mode = 0;
  logic        hold = 1'b0;
  logic [11:0] hres;
  logic [7:0]  htag;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  function automatic int k2ref(input int a, input int b);
    int c, t, u;
    c = (a * b) & 'hFFFFFF;
    t = 13 * (c & 255) - (c >> 8);
    u = 13 * (t & 255) - ((t - (t & 255)) / 256);
    if (u < 0) u += 3329;
    return u;
  endfunction

  always @(posedge clk) cyc++;

  // monitor: drives out_ready, checks hold stability and pops the scoreboard on each transfer
  always @(negedge clk) begin
    out_ready = (rdy_mode == 0) ? 1'b1 : (rdy_mode == 1) ? 1'b0 : 1'($urandom_range(0, 1));
    #1;
    if (rst) hold = 1'b0;
    else begin
      if (hold) begin
        chk("stable_res", 32'(out_res), 32'(hres));
        chk("stable_tag", 32'(out_tag), 32'(htag));
      end
      hold = out_valid && !out_ready;
      hres = out_res;
      htag = out_tag;
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_out: got res %0d tag %0d, expected no output", out_res, out_tag);
        end else begin
          e_m = q.pop_front();
          chk("res", 32'(out_res), 32'(e_m.exp));
          chk("tag", 32'(out_tag), 32'(e_m.tag));
          chk("congruence", 32'(int'(out_res) % 3329),
              32'(int'((longint'(169) * e_m.a * e_m.b) % 3329)));
          got++;
          if (first_c < 0) first_c = cyc;
          last_c = cyc;
        end
      end
    end
  end

  task automatic send(input int a, input int b, input int t, input int exp);
    int n;
    @(negedge clk);
    in_valid = 1'b1;
    in_a = 12'(a);
    in_b = 12'(b);
    in_tag = 8'(t);
    #2;
    n = 0;
    while (!in_ready && n < 1000) begin
      @(negedge clk);
      #2;
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: in_ready %0d expected 1", in_ready);
      in_valid = 1'b0;
    end else begin
      q.push_back('{a, b, t, exp});
      sent++;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() > 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d pending, expected 0", q.size());
      q.delete();
    end
  endtask

  int dir[6][3] = '{'{0, 2000, 0}, '{3328, 3328, 169}, '{2, 3, 1014},
                    '{100, 100, 2197}, '{3328, 1, 3160}, '{36, 29, 3328}};

  initial begin
    int a, b, s0;
    rst = 1'b1;
    idle(2);
    #2;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_res", 32'(out_res), 0);
    chk("rst_out_tag", 32'(out_tag), 0);
    chk("rst_err", 32'(err_range), 0);
    chk("rst_busy", 32'(busy), 0);
    rst = 1'b0;
    idle(1);
    #2;
    chk("rst_in_ready", 32'(in_ready), 1);

    send(1, 1, 'h11, 169);
    idle(1);
    #2;
    chk("single_in_ready", 32'(in_ready), 1);
    drain();
    foreach (dir[i]) send(dir[i][0], dir[i][1], 'h20 + i, dir[i][2]);
    drain();
    chk("err_clean", 32'(err_range), 0);

    first_c = -1;
    s0 = got;
    for (int i = 0; i < 100; i++) begin
      a = $urandom_range(0, 3328);
      b = $urandom_range(0, 3328);
      send(a, b, i, k2ref(a, b));
    end
    drain();
    chk("stream_count", 32'(got - s0), 100);
    chk("stream_back_to_back", 32'(last_c - first_c), 99);

    rdy_mode = 1;
    s0 = sent;
    fork
      for (int i = 0; i < 5; i++) send(100 + i, 200 + i, 'h40 + i, k2ref(100 + i, 200 + i));
    join_none
    idle(12);
    #3;
    chk("bp_accepted", 32'(sent - s0), 3);
    chk("bp_in_ready", 32'(in_ready), 0);
    chk("bp_out_valid", 32'(out_valid), 1);
    rdy_mode = 0;
    wait fork;
    drain();
    chk("bp_total", 32'(sent - s0), 5);

    send(3329, 1, 'h77, 0);
    idle(1);
    #2;
    chk("err_set", 32'(err_range), 1);
    send(4095, 4095, 'h78, 841);
    drain();
    rdy_mode = 2;
    for (int i = 0; i < 10000; i++) begin
      if ($urandom_range(0, 3) == 0) idle(1);
      a = $urandom_range(0, 3328);
      b = $urandom_range(0, 3328);
      send(a, b, i & 255, k2ref(a, b));
    end
    drain();
    chk("err_sticky", 32'(err_range), 1);

    rdy_mode = 1;
    send(5, 6, 'h91, k2ref(5, 6));
    send(7, 8, 'h92, k2ref(7, 8));
    idle(1);
    rst = 1'b1;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 0);
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_err", 32'(err_range), 0);
    q.delete();
    idle(2);
    rst = 1'b0;
    rdy_mode = 0;
    idle(10);
    #2;
    chk("midrst_dropped", 32'(out_valid), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
